// File: rtl/encode_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : encode_mul_pipe
// Brief    : Pipelined mixed-sign multiplier with round-half-up right shift
//            and saturating or wrapping narrowing to a signed DOUT_WIDTH result.
// Revision : 1.0 - initial release
// ============================================================================
module encode_mul_pipe #(
  parameter int DIN0_WIDTH = 40,
  parameter int DIN1_WIDTH = 28,
  parameter int DOUT_WIDTH = 67,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0,
  parameter int SAT        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int C_PW = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam int C_HW = C_PW - DOUT_WIDTH + 2;
  // Half an LSB of the shifted result; collapses to zero when SHIFT is 0.
  localparam logic signed [C_PW:0] C_RND = ((C_PW+1)'(1) << SHIFT) >> 1;

  logic signed [DIN0_WIDTH:0] w_a;
  logic signed [DIN1_WIDTH:0] w_b;
  logic signed [C_PW-1:0]     w_prod;
  logic signed [C_PW-1:0]     w_rs_in;
  logic signed [C_PW:0]       w_sum;
  logic signed [C_PW:0]       w_shifted;
  logic [C_HW-1:0]            w_hi;
  logic                       w_ovf;
  logic [DOUT_WIDTH-1:0]      w_res;
  logic [NUM_STAGE:0]         w_vld_cat;

  logic [NUM_STAGE-1:0]       vld_d, vld_q;
  logic [DOUT_WIDTH-1:0]      dout_d, dout_q;
  logic                       ovf_d, ovf_q;

  always_comb begin
    w_a    = {mode[1] & din0[DIN0_WIDTH-1], din0};
    w_b    = {mode[0] & din1[DIN1_WIDTH-1], din1};
    w_prod = C_PW'(w_a) * C_PW'(w_b);
  end

  // Result fits only if every bit from the target sign bit upward agrees.
  always_comb begin
    w_sum     = {w_rs_in[C_PW-1], w_rs_in} + C_RND;
    w_shifted = w_sum >>> SHIFT;
    w_hi      = w_shifted[C_PW:DOUT_WIDTH-1];
    w_ovf     = ~((&w_hi) | ~(|w_hi));
    w_res     = w_shifted[DOUT_WIDTH-1:0];
    if (w_ovf && (SAT != 0)) begin
      w_res = w_shifted[C_PW] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                              : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
  end

  generate
    if (NUM_STAGE == 1) begin : g_comb
      assign w_rs_in = w_prod;
    end else begin : g_pipe
      logic signed [C_PW-1:0] prod_d [NUM_STAGE-1];
      logic signed [C_PW-1:0] prod_q [NUM_STAGE-1];

      always_comb begin
        prod_d[0] = (ce && in_valid) ? w_prod : prod_q[0];
        for (int i = 1; i < NUM_STAGE - 1; i++) begin
          prod_d[i] = (ce && w_vld_cat[i]) ? prod_q[i-1] : prod_q[i];
        end
      end

      always_ff @(posedge clk) begin
        prod_q <= prod_d;
      end

      assign w_rs_in = prod_q[NUM_STAGE-2];
    end
  endgenerate

  // Bit i is the valid feeding stage i; the top bit is the output valid.
  assign w_vld_cat = {vld_q, in_valid};

  always_comb begin
    vld_d  = vld_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (ce) begin
      vld_d = w_vld_cat[NUM_STAGE-1:0];
      if (w_vld_cat[NUM_STAGE-1]) begin
        dout_d = w_res;
        ovf_d  = w_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = w_vld_cat[NUM_STAGE];
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_encode_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_encode_mul_pipe
// Brief    : Directed and randomised self-checking bench for encode_mul_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encode_mul_pipe;

  localparam int N_RAND = 10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] din0 = 8'h00;
  logic [7:0] din1 = 8'h00;
  logic [1:0] mode = 2'b00;

  int checks = 0;
  int failures = 0;

  logic        d1_ov, d1_of;
  logic [11:0] d1_do;
  logic        d2_ov, d2_of;
  logic [15:0] d2_do;
  logic        d3s_ov, d3s_of;
  logic [7:0]  d3s_do;
  logic        d3w_ov, d3w_of;
  logic [7:0]  d3w_do;
  logic        d4_ov, d4_of;
  logic [11:0] d4_do;

  // Per-DUT configuration for the model-driven loops: d1, d2, d3s, d4.
  int ns_k  [4] = '{1, 2, 3, 4};
  int sh_k  [4] = '{3, 0, 2, 3};
  int dw_k  [4] = '{12, 16, 8, 12};
  int sat_k [4] = '{1, 1, 1, 0};

  logic        obs_v [4];
  logic [63:0] obs_d [4];
  logic        obs_o [4];

  logic [7:0] ra  [N_RAND];
  logic [7:0] rb  [N_RAND];
  logic [1:0] rm  [N_RAND];
  bit         riv [N_RAND];

  always #5 clk = ~clk;

  encode_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(12), .NUM_STAGE(1),
                    .SHIFT(3), .SAT(1)) u_d1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .mode(mode), .out_valid(d1_ov), .dout(d1_do), .ovf(d1_of));

  encode_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(2),
                    .SHIFT(0), .SAT(1)) u_d2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .mode(mode), .out_valid(d2_ov), .dout(d2_do), .ovf(d2_of));

  encode_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(3),
                    .SHIFT(2), .SAT(1)) u_d3s (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .mode(mode), .out_valid(d3s_ov), .dout(d3s_do), .ovf(d3s_of));

  encode_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(3),
                    .SHIFT(2), .SAT(0)) u_d3w (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .mode(mode), .out_valid(d3w_ov), .dout(d3w_do), .ovf(d3w_of));

  encode_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(12), .NUM_STAGE(4),
                    .SHIFT(3), .SAT(0)) u_d4 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .mode(mode), .out_valid(d4_ov), .dout(d4_do), .ovf(d4_of));

  // Reference: exact integer product, round-half-up shift, then clamp or wrap.
  function automatic longint model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [1:0] m, input int sh, input int dw,
                                   input bit sat, output bit ov);
    longint av, bv, p, mx, mn;
    av = longint'(a);
    bv = longint'(b);
    if (m[1] && a[7]) av = av - 256;
    if (m[0] && b[7]) bv = bv - 256;
    p = av * bv;
    if (sh > 0) p = (p + (longint'(1) << (sh - 1))) >>> sh;
    mx = (longint'(1) << (dw - 1)) - 1;
    mn = -mx - 1;
    ov = (p > mx) || (p < mn);
    if (ov && sat) p = (p > mx) ? mx : mn;
    return p & ((longint'(1) << dw) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m);
    in_valid = v;
    din0     = a;
    din1     = b;
    mode     = m;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sample_obs();
    obs_v[0] = d1_ov;  obs_d[0] = 64'(d1_do);  obs_o[0] = d1_of;
    obs_v[1] = d2_ov;  obs_d[1] = 64'(d2_do);  obs_o[1] = d2_of;
    obs_v[2] = d3s_ov; obs_d[2] = 64'(d3s_do); obs_o[2] = d3s_of;
    obs_v[3] = d4_ov;  obs_d[3] = 64'(d4_do);  obs_o[3] = d4_of;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({d1_ov, d1_do, d1_of} !== 14'h0) begin
      failures++; $display("FAIL reset_d1 got=%h exp=0", {d1_ov, d1_do, d1_of});
    end
    checks++;
    if ({d2_ov, d2_do, d2_of} !== 18'h0) begin
      failures++; $display("FAIL reset_d2 got=%h exp=0", {d2_ov, d2_do, d2_of});
    end
    checks++;
    if ({d3s_ov, d3s_do, d3s_of, d3w_ov, d3w_do, d3w_of} !== 20'h0) begin
      failures++; $display("FAIL reset_d3 got=%h exp=0", {d3s_ov, d3s_do, d3s_of, d3w_ov, d3w_do, d3w_of});
    end
    checks++;
    if ({d4_ov, d4_do, d4_of} !== 14'h0) begin
      failures++; $display("FAIL reset_d4 got=%h exp=0", {d4_ov, d4_do, d4_of});
    end
    tick();
    tick();
    reset = 1'b0;
    ce    = 1'b1;
    tick();
    checks++;
    if ({d1_ov, d2_ov, d3s_ov, d4_ov} !== 4'b0) begin
      failures++; $display("FAIL reset_idle_valid got=%b exp=0000", {d1_ov, d2_ov, d3s_ov, d4_ov});
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 8'hFF, 8'hFF, 2'b10);
    tick();
    checks++;
    if (d2_ov !== 1'b0) begin
      failures++; $display("FAIL basic_d2_early got=%b exp=0", d2_ov);
    end
    checks++;
    if ({d1_ov, d1_do, d1_of} !== {1'b1, 12'hFE0, 1'b0}) begin
      failures++; $display("FAIL basic_d1 got=%h exp=%h", {d1_ov, d1_do, d1_of}, {1'b1, 12'hFE0, 1'b0});
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    checks++;
    if ({d2_ov, d2_do, d2_of} !== {1'b1, 16'hFF01, 1'b0}) begin
      failures++; $display("FAIL basic_d2 got=%h exp=%h", {d2_ov, d2_do, d2_of}, {1'b1, 16'hFF01, 1'b0});
    end
    checks++;
    if ({d1_ov, d1_do, d1_of} !== {1'b0, 12'hFE0, 1'b0}) begin
      failures++; $display("FAIL basic_d1_hold got=%h exp=%h", {d1_ov, d1_do, d1_of}, {1'b0, 12'hFE0, 1'b0});
    end
  endtask

  task automatic test_round_sat();
    drive(1'b1, 8'h03, 8'h03, 2'b11);
    tick();
    drive(1'b1, 8'hFD, 8'h03, 2'b11);
    tick();
    drive(1'b1, 8'h7F, 8'h7F, 2'b11);
    tick();
    checks++;
    if ({d3s_ov, d3s_do, d3s_of, d3w_ov, d3w_do, d3w_of} !== {1'b1, 8'h02, 1'b0, 1'b1, 8'h02, 1'b0}) begin
      failures++; $display("FAIL round_pos got=%h exp=%h", {d3s_ov, d3s_do, d3s_of, d3w_ov, d3w_do, d3w_of},
                           {1'b1, 8'h02, 1'b0, 1'b1, 8'h02, 1'b0});
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    checks++;
    if ({d3s_ov, d3s_do, d3s_of, d3w_ov, d3w_do, d3w_of} !== {1'b1, 8'hFE, 1'b0, 1'b1, 8'hFE, 1'b0}) begin
      failures++; $display("FAIL round_neg got=%h exp=%h", {d3s_ov, d3s_do, d3s_of, d3w_ov, d3w_do, d3w_of},
                           {1'b1, 8'hFE, 1'b0, 1'b1, 8'hFE, 1'b0});
    end
    tick();
    checks++;
    if ({d3s_ov, d3s_do, d3s_of} !== {1'b1, 8'h7F, 1'b1}) begin
      failures++; $display("FAIL sat_clamp got=%h exp=%h", {d3s_ov, d3s_do, d3s_of}, {1'b1, 8'h7F, 1'b1});
    end
    checks++;
    if ({d3w_ov, d3w_do, d3w_of} !== {1'b1, 8'hC0, 1'b1}) begin
      failures++; $display("FAIL sat_wrap got=%h exp=%h", {d3w_ov, d3w_do, d3w_of}, {1'b1, 8'hC0, 1'b1});
    end
    tick();
    checks++;
    if ({d3s_ov, d3s_do, d3s_of} !== {1'b0, 8'h7F, 1'b1}) begin
      failures++; $display("FAIL sat_hold got=%h exp=%h", {d3s_ov, d3s_do, d3s_of}, {1'b0, 8'h7F, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [10] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h12, 8'hC3, 8'h3C};
    logic [7:0] vb [10] = '{8'h10, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h02, 8'h81, 8'hEE, 8'h3C, 8'h07};
    logic [1:0] vm [10] = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
    for (int t = 0; t < 13; t++) begin
      if (t < 10) drive(1'b1, va[t], vb[t], vm[t]);
      else in_valid = 1'b0;
      tick();
      sample_obs();
      for (int k = 0; k < 4; k++) begin
        int     idx;
        bit     ev, eo;
        longint ed;
        idx = t - ns_k[k] + 1;
        ev  = (idx >= 0) && (idx < 10);
        ed  = 0;
        eo  = 1'b0;
        if (ev) ed = model(va[idx], vb[idx], vm[idx], sh_k[k], dw_k[k], sat_k[k] != 0, eo);
        checks++;
        if (obs_v[k] !== ev || (ev && (obs_d[k] !== 64'(ed) || obs_o[k] !== eo))) begin
          failures++;
          $display("FAIL b2b dut=%0d t=%0d got v=%b d=%h o=%b exp v=%b d=%h o=%b",
                   k, t, obs_v[k], obs_d[k], obs_o[k], ev, ed, eo);
        end
      end
    end
  endtask

  task automatic test_ce();
    bit          ce_pat [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    int          e2 [9] = '{-1, 0, 1, 1, 1, 2, -1, -1, -1};
    int          e3 [9] = '{-1, -1, 0, 0, 0, 1, 2, -1, -1};
    logic [7:0]  ca [3] = '{8'h05, 8'hF0, 8'h7F};
    logic [7:0]  cb [3] = '{8'h07, 8'h03, 8'hFF};
    logic [1:0]  cm [3] = '{2'b11, 2'b11, 2'b00};
    logic [15:0] v2 [3] = '{16'h0023, 16'hFFD0, 16'h7E81};
    logic [7:0]  v3 [3] = '{8'h09, 8'hF4, 8'h7F};
    logic        o3 [3] = '{1'b0, 1'b0, 1'b1};
    int          last2 = -1;
    int          last3 = -1;
    for (int t = 0; t < 9; t++) begin
      ce = ce_pat[t];
      if (t < 3) drive(1'b1, ca[t], cb[t], cm[t]);
      else in_valid = 1'b0;
      tick();
      if (e2[t] >= 0) last2 = e2[t];
      if (e3[t] >= 0) last3 = e3[t];
      checks++;
      if (last2 < 0) begin
        if (d2_ov !== 1'b0) begin
          failures++; $display("FAIL ce_d2 t=%0d got v=%b exp v=0", t, d2_ov);
        end
      end else if ({d2_ov, d2_do, d2_of} !== {e2[t] >= 0, v2[last2], 1'b0}) begin
        failures++; $display("FAIL ce_d2 t=%0d got=%h exp=%h", t, {d2_ov, d2_do, d2_of}, {e2[t] >= 0, v2[last2], 1'b0});
      end
      checks++;
      if (last3 < 0) begin
        if (d3s_ov !== 1'b0) begin
          failures++; $display("FAIL ce_d3 t=%0d got v=%b exp v=0", t, d3s_ov);
        end
      end else if ({d3s_ov, d3s_do, d3s_of} !== {e3[t] >= 0, v3[last3], o3[last3]}) begin
        failures++; $display("FAIL ce_d3 t=%0d got=%h exp=%h", t, {d3s_ov, d3s_do, d3s_of}, {e3[t] >= 0, v3[last3], o3[last3]});
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 8'h03, 8'h05, 2'b00);
    tick();
    drive(1'b1, 8'hFF, 8'hFF, 2'b00);
    tick();
    checks++;
    if ({d2_ov, d2_do, d2_of, d1_ov, d1_do, d1_of} !== {1'b1, 16'h000F, 1'b0, 1'b1, 12'h7FF, 1'b1}) begin
      failures++; $display("FAIL rst_pre got=%h exp=%h", {d2_ov, d2_do, d2_of, d1_ov, d1_do, d1_of},
                           {1'b1, 16'h000F, 1'b0, 1'b1, 12'h7FF, 1'b1});
    end
    in_valid = 1'b0;
    ce       = 1'b0;
    reset    = 1'b1;
    #1;
    checks++;
    if ({d1_ov, d1_do, d1_of, d2_ov, d2_do, d2_of} !== 32'h0) begin
      failures++; $display("FAIL rst_async_d1d2 got=%h exp=0", {d1_ov, d1_do, d1_of, d2_ov, d2_do, d2_of});
    end
    checks++;
    if ({d3s_ov, d3s_do, d3s_of, d4_ov, d4_do, d4_of} !== 24'h0) begin
      failures++; $display("FAIL rst_async_d3d4 got=%h exp=0", {d3s_ov, d3s_do, d3s_of, d4_ov, d4_do, d4_of});
    end
    tick();
    tick();
    reset = 1'b0;
    ce    = 1'b1;
    drive(1'b1, 8'h02, 8'h03, 2'b11);
    tick();
    checks++;
    if ({d1_ov, d1_do, d1_of, d2_ov, d2_do, d2_of} !== {1'b1, 12'h001, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      failures++; $display("FAIL rst_post_a got=%h exp=%h", {d1_ov, d1_do, d1_of, d2_ov, d2_do, d2_of},
                           {1'b1, 12'h001, 1'b0, 1'b0, 16'h0000, 1'b0});
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({d2_ov, d2_do, d2_of, d3s_ov, d3s_do, d3s_of} !== {1'b1, 16'h0006, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++; $display("FAIL rst_post_b got=%h exp=%h", {d2_ov, d2_do, d2_of, d3s_ov, d3s_do, d3s_of},
                           {1'b1, 16'h0006, 1'b0, 1'b0, 8'h00, 1'b0});
    end
    tick();
    checks++;
    if ({d3s_ov, d3s_do, d3s_of, d4_ov, d4_do, d4_of} !== {1'b1, 8'h02, 1'b0, 1'b0, 12'h000, 1'b0}) begin
      failures++; $display("FAIL rst_post_c got=%h exp=%h", {d3s_ov, d3s_do, d3s_of, d4_ov, d4_do, d4_of},
                           {1'b1, 8'h02, 1'b0, 1'b0, 12'h000, 1'b0});
    end
    tick();
    checks++;
    if ({d4_ov, d4_do, d4_of} !== {1'b1, 12'h001, 1'b0}) begin
      failures++; $display("FAIL rst_post_d got=%h exp=%h", {d4_ov, d4_do, d4_of}, {1'b1, 12'h001, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < N_RAND; i++) begin
      ra[i]  = 8'($urandom_range(0, 255));
      rb[i]  = 8'($urandom_range(0, 255));
      rm[i]  = 2'($urandom_range(0, 3));
      riv[i] = ($urandom_range(0, 3) != 0);
    end
    for (int t = 0; t < N_RAND + 3; t++) begin
      if (t < N_RAND) drive(riv[t], ra[t], rb[t], rm[t]);
      else in_valid = 1'b0;
      tick();
      sample_obs();
      for (int k = 0; k < 4; k++) begin
        int     idx;
        bit     ev, eo;
        longint ed;
        idx = t - ns_k[k] + 1;
        ev  = (idx >= 0) && (idx < N_RAND) && riv[idx];
        ed  = 0;
        eo  = 1'b0;
        if (ev) ed = model(ra[idx], rb[idx], rm[idx], sh_k[k], dw_k[k], sat_k[k] != 0, eo);
        checks++;
        if (obs_v[k] !== ev || (ev && (obs_d[k] !== 64'(ed) || obs_o[k] !== eo))) begin
          failures++;
          $display("FAIL rand dut=%0d t=%0d got v=%b d=%h o=%b exp v=%b d=%h o=%b",
                   k, t, obs_v[k], obs_d[k], obs_o[k], ev, ed, eo);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    idle(5);
    test_round_sat();
    idle(5);
    test_back_to_back();
    idle(5);
    test_ce();
    idle(5);
    test_reset_midstream();
    idle(5);
    test_random();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
